// File: rtl/if_id_reg.sv
// ----------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register of the 5-stage MIPS core. Captures the fetched
// instruction and PC+PC_STEP, holds them across stalls and clears them to a
// bubble on flush. Decoded instruction fields are pure slices of the
// registered word. A saturating counter tracks stalled (non-flushed) cycles.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   if_instr     in   [31:0] fetched instruction word
//   if_pc        in   [31:0] PC of if_instr
//   if_valid     in   if_instr/if_pc carry a real instruction
//   stall        in   hold current contents
//   flush        in   discard current contents (beats stall)
//   id_instr     out  [31:0] registered instruction
//   id_pc_plus4  out  [31:0] registered if_pc + PC_STEP
//   id_valid     out  id_instr is a real instruction (0 = bubble)
//   id_opcode/id_rs/id_rt/id_rd/id_shamt/id_funct/id_imm16/id_target
//                out  field slices of id_instr
//   stall_cnt    out  [CNT_WIDTH-1:0] saturating stalled-cycle count
// ----------------------------------------------------------------------------
module if_id_reg #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
    parameter int unsigned PC_STEP   = 4,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          if_instr,
    input  logic [31:0]          if_pc,
    input  logic                 if_valid,
    input  logic                 stall,
    input  logic                 flush,
    output logic [31:0]          id_instr,
    output logic [31:0]          id_pc_plus4,
    output logic                 id_valid,
    output logic [5:0]           id_opcode,
    output logic [4:0]           id_rs,
    output logic [4:0]           id_rt,
    output logic [4:0]           id_rd,
    output logic [4:0]           id_shamt,
    output logic [5:0]           id_funct,
    output logic [15:0]          id_imm16,
    output logic [25:0]          id_target,
    output logic [CNT_WIDTH-1:0] stall_cnt
);

    localparam logic [31:0] STEP = 32'(PC_STEP);

    logic [31:0]          r_instr;
    logic [31:0]          r_pc_plus4;
    logic                 r_valid;
    logic [CNT_WIDTH-1:0] r_stall_cnt;
    logic [31:0]          w_pc_next;

    // 32-bit modulo add; carry out is intentionally dropped.
    assign w_pc_next = if_pc + STEP;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr    <= NOP_INSTR;
            r_pc_plus4 <= '0;
            r_valid    <= 1'b0;
        end else if (flush) begin
            r_instr    <= NOP_INSTR;
            r_pc_plus4 <= '0;
            r_valid    <= 1'b0;
        end else if (!stall) begin
            // Word and PC are loaded even when if_valid is low; the cleared
            // valid bit is what marks the bubble downstream.
            r_instr    <= if_instr;
            r_pc_plus4 <= w_pc_next;
            r_valid    <= if_valid;
        end
    end

    // Counts only stalls that actually hold the register; flush leaves it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (stall && !flush && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign id_instr    = r_instr;
    assign id_pc_plus4 = r_pc_plus4;
    assign id_valid    = r_valid;
    assign stall_cnt   = r_stall_cnt;

    assign id_opcode   = r_instr[31:26];
    assign id_rs       = r_instr[25:21];
    assign id_rt       = r_instr[20:16];
    assign id_rd       = r_instr[15:11];
    assign id_shamt    = r_instr[10:6];
    assign id_funct    = r_instr[5:0];
    assign id_imm16    = r_instr[15:0];
    assign id_target   = r_instr[25:0];

endmodule

// File: tb/tb_if_id_reg.sv
// ----------------------------------------------------------------------------
// tb_if_id_reg
// Directed self-checking bench for if_id_reg. Two instances share stimulus:
// one with the default 16-bit stall counter, one with a 4-bit counter so that
// saturation can be reached quickly.
// ----------------------------------------------------------------------------
module tb_if_id_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_valid;
    logic        stall;
    logic        flush;

    logic [31:0] id_instr,    id_instr4;
    logic [31:0] id_pc_plus4, id_pc_plus44;
    logic        id_valid,    id_valid4;
    logic [5:0]  id_opcode,   id_opcode4;
    logic [4:0]  id_rs,       id_rs4;
    logic [4:0]  id_rt,       id_rt4;
    logic [4:0]  id_rd,       id_rd4;
    logic [4:0]  id_shamt,    id_shamt4;
    logic [5:0]  id_funct,    id_funct4;
    logic [15:0] id_imm16,    id_imm164;
    logic [25:0] id_target,   id_target4;
    logic [15:0] stall_cnt;
    logic [3:0]  stall_cnt4;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    if_id_reg dut (
        .clk(clk), .rst(rst), .if_instr(if_instr), .if_pc(if_pc),
        .if_valid(if_valid), .stall(stall), .flush(flush),
        .id_instr(id_instr), .id_pc_plus4(id_pc_plus4), .id_valid(id_valid),
        .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_shamt(id_shamt), .id_funct(id_funct), .id_imm16(id_imm16),
        .id_target(id_target), .stall_cnt(stall_cnt)
    );

    if_id_reg #(.CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .if_instr(if_instr), .if_pc(if_pc),
        .if_valid(if_valid), .stall(stall), .flush(flush),
        .id_instr(id_instr4), .id_pc_plus4(id_pc_plus44), .id_valid(id_valid4),
        .id_opcode(id_opcode4), .id_rs(id_rs4), .id_rt(id_rt4), .id_rd(id_rd4),
        .id_shamt(id_shamt4), .id_funct(id_funct4), .id_imm16(id_imm164),
        .id_target(id_target4), .stall_cnt(stall_cnt4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; if_instr = 32'h0; if_pc = 32'h0; if_valid = 1'b0;
        stall = 1'b0; flush = 1'b0;

        // Reset for two cycles
        tick(); tick();
        chk("rst_instr",  id_instr, 32'h0);
        chk("rst_pc",     id_pc_plus4, 32'h0);
        chk("rst_valid",  32'(id_valid), 32'h0);
        chk("rst_cnt",    32'(stall_cnt), 32'h0);
        chk("rst_opcode", 32'(id_opcode), 32'h0);
        chk("rst_cnt4",   32'(stall_cnt4), 32'h0);

        // Plain load: addi $t0,$0,-1
        rst = 1'b0; if_instr = 32'h2008_FFFF; if_pc = 32'h0040_0000; if_valid = 1'b1;
        tick();
        chk("ld_opcode", 32'(id_opcode), 32'h08);
        chk("ld_rs",     32'(id_rs), 32'h0);
        chk("ld_rt",     32'(id_rt), 32'h8);
        chk("ld_imm16",  32'(id_imm16), 32'hFFFF);
        chk("ld_pc",     id_pc_plus4, 32'h0040_0004);
        chk("ld_valid",  32'(id_valid), 32'h1);

        // Load lui, then stall three cycles while the fetch input changes
        if_instr = 32'h3C01_8000; if_pc = 32'h0040_0004;
        tick();
        chk("lui_instr", id_instr, 32'h3C01_8000);
        chk("lui_pc",    id_pc_plus4, 32'h0040_0008);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if_instr = 32'h1111_1111 * 32'(i + 1);
            if_pc    = 32'h0000_1000 + 32'(i * 4);
            tick();
            chk("stall_instr", id_instr, 32'h3C01_8000);
            chk("stall_imm16", 32'(id_imm16), 32'h8000);
            chk("stall_pc",    id_pc_plus4, 32'h0040_0008);
            chk("stall_cnt",   32'(stall_cnt), 32'(i + 1));
        end

        // First unstalled edge loads what is present now
        stall = 1'b0; if_instr = 32'hAAAA_0001; if_pc = 32'h0000_0100;
        tick();
        chk("resume_instr", id_instr, 32'hAAAA_0001);
        chk("resume_pc",    id_pc_plus4, 32'h0000_0104);
        chk("resume_cnt",   32'(stall_cnt), 32'd3);

        // Flush and stall together: flush wins, counter untouched
        stall = 1'b1; flush = 1'b1;
        tick();
        chk("flush_instr", id_instr, 32'h0);
        chk("flush_valid", 32'(id_valid), 32'h0);
        chk("flush_pc",    id_pc_plus4, 32'h0);
        chk("flush_cnt",   32'(stall_cnt), 32'd3);

        // PC wrap
        stall = 1'b0; flush = 1'b0;
        if_instr = 32'h8C22_0010; if_pc = 32'hFFFF_FFFC; if_valid = 1'b1;
        tick();
        chk("wrap_pc",    id_pc_plus4, 32'h0000_0000);
        chk("wrap_valid", 32'(id_valid), 32'h1);

        // Invalid fetch still loads word and PC
        if_instr = 32'hDEAD_BEEF; if_pc = 32'h0000_0200; if_valid = 1'b0;
        tick();
        chk("inv_valid",  32'(id_valid), 32'h0);
        chk("inv_instr",  id_instr, 32'hDEAD_BEEF);
        chk("inv_pc",     id_pc_plus4, 32'h0000_0204);
        chk("inv_opcode", 32'(id_opcode), 32'h37);
        chk("inv_rs",     32'(id_rs), 32'h15);
        chk("inv_rt",     32'(id_rt), 32'h0D);
        chk("inv_rd",     32'(id_rd), 32'h17);
        chk("inv_shamt",  32'(id_shamt), 32'h1B);
        chk("inv_funct",  32'(id_funct), 32'h2F);
        chk("inv_target", 32'(id_target), 32'h02AD_BEEF);

        // Long stall: 4-bit counter saturates, 16-bit keeps counting
        stall = 1'b1; if_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if_instr = 32'h0000_0000 + 32'(i);
            tick();
            if (i == 11) chk("sat_cnt4_15", 32'(stall_cnt4), 32'hF);
        end
        chk("sat_cnt4",   32'(stall_cnt4), 32'hF);
        chk("sat_cnt16",  32'(stall_cnt), 32'd23);
        chk("sat_instr",  id_instr, 32'hDEAD_BEEF);
        chk("sat_valid",  32'(id_valid), 32'h0);

        // Reset while stalled
        stall = 1'b0; if_instr = 32'h0109_4020; if_pc = 32'h0000_0300; if_valid = 1'b1;
        tick();
        chk("pre_rst_valid", 32'(id_valid), 32'h1);
        stall = 1'b1;
        tick();
        chk("pre_rst_cnt", 32'(stall_cnt), 32'd24);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_valid", 32'(id_valid), 32'h0);
        chk("mrst_instr", id_instr, 32'h0);
        chk("mrst_pc",    id_pc_plus4, 32'h0);
        chk("mrst_cnt",   32'(stall_cnt), 32'h0);
        chk("mrst_cnt4",  32'(stall_cnt4), 32'h0);
        tick();
        chk("post_rst_instr", id_instr, 32'h0);
        chk("post_rst_valid", 32'(id_valid), 32'h0);
        chk("post_rst_cnt",   32'(stall_cnt), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
